// File: rtl/pt_feedback_pkg.sv
// ---------------------------------------------------------------------------
// pt_feedback_pkg
// Shared helpers for the pt_feedback blocks:
//   clog2      - ceiling log2 for parameter derivation
//   sum_width  - width needed to add n signed samples of in_w bits
//   saturate   - clip a signed value into the range of a width-bit signed word
// No ports; import with "import pt_feedback_pkg::*;".
// ---------------------------------------------------------------------------
package pt_feedback_pkg;

    // Working width of saturate(). Any lane width up to this fits.
    localparam int SAT_W = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Adding n signed values of in_w bits needs clog2(n) extra bits.
    function automatic int sum_width(input int in_w, input int n);
        return in_w + clog2(n);
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int                      width
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/shift_saturate_lane.sv
// ---------------------------------------------------------------------------
// shift_saturate_lane
// One output lane: clamp the requested gain to MAX_LOG2_GAIN, shift the sum
// left by it, clip to OUTPUT_WIDTH and register the result.
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset (clears data_o)
//   sum_i   in   signed masked sum, SUM_WIDTH bits
//   gain_i  in   log2 gain request, WIDTH_LOG2_GAIN bits
//   data_o  out  registered, saturated lane output
//   clip_o  out  combinational: the value being registered this cycle clips
// ---------------------------------------------------------------------------
module shift_saturate_lane
    import pt_feedback_pkg::*;
#(
    parameter int SUM_WIDTH       = 16,
    parameter int OUTPUT_WIDTH    = 14,
    parameter int MAX_LOG2_GAIN   = 3,
    parameter int WIDTH_LOG2_GAIN = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [SUM_WIDTH-1:0] sum_i,
    input  logic [WIDTH_LOG2_GAIN-1:0]  gain_i,
    output logic [OUTPUT_WIDTH-1:0]     data_o,
    output logic                        clip_o
);

    // Wide enough that the largest shift can never overflow.
    localparam int SHIFT_WIDTH = SUM_WIDTH + MAX_LOG2_GAIN;

    logic [31:0]                    shift_amt;
    logic signed [SHIFT_WIDTH-1:0]  shifted;
    logic signed [SAT_W-1:0]        wide;
    logic signed [SAT_W-1:0]        clipped;
    logic [OUTPUT_WIDTH-1:0]        data_d;
    logic [OUTPUT_WIDTH-1:0]        data_q;

    always_comb begin
        if (32'(gain_i) > 32'(MAX_LOG2_GAIN)) begin
            shift_amt = 32'(MAX_LOG2_GAIN);
        end else begin
            shift_amt = 32'(gain_i);
        end
        shifted = SHIFT_WIDTH'(sum_i) <<< shift_amt;
        wide    = SAT_W'(shifted);
        clipped = saturate(wide, OUTPUT_WIDTH);
        clip_o  = (clipped != wide);
        data_d  = clipped[OUTPUT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/conditional_adder_gain_nxm.sv
// ---------------------------------------------------------------------------
// conditional_adder_gain_nxm
// N-input, M-output mixer: each output adds a selected subset of the signed
// inputs, applies a power-of-two gain and saturates. Three register stages:
// input/config capture, masked sum, shift+saturate.
// Ports:
//   clk_i         in   clock
//   rst_i         in   synchronous active-high reset
//   data_i        in   packed signed inputs, channel k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   add_select_i  in   shadow select, field j (N_INPUTS bits) for output j
//   log2_gain_i   in   shadow gain, field j (WIDTH_LOG2_GAIN bits) for output j
//   update_i      in   load shadow select/gain into the active config
//   sat_clear_i   in   clear all sticky saturation flags
//   data_o        out  packed signed outputs, output j at [j*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//   valid_o       out  data_o holds real samples (pipeline filled)
//   sat_o         out  sticky saturation flag per output
// ---------------------------------------------------------------------------
module conditional_adder_gain_nxm
    import pt_feedback_pkg::*;
#(
    parameter int N_INPUTS        = 4,
    parameter int N_OUTPUTS       = 2,
    parameter int INPUT_WIDTH     = 14,
    parameter int OUTPUT_WIDTH    = 14,
    parameter int MAX_LOG2_GAIN   = 3,
    parameter int WIDTH_LOG2_GAIN = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [N_INPUTS*INPUT_WIDTH-1:0]       data_i,
    input  logic [N_OUTPUTS*N_INPUTS-1:0]         add_select_i,
    input  logic [N_OUTPUTS*WIDTH_LOG2_GAIN-1:0]  log2_gain_i,
    input  logic                                  update_i,
    input  logic                                  sat_clear_i,
    output logic [N_OUTPUTS*OUTPUT_WIDTH-1:0]     data_o,
    output logic                                  valid_o,
    output logic [N_OUTPUTS-1:0]                  sat_o
);

    localparam int SUM_WIDTH = sum_width(INPUT_WIDTH, N_INPUTS);

    // Active configuration
    logic [N_OUTPUTS*N_INPUTS-1:0]         sel_act_q;
    logic [N_OUTPUTS*WIDTH_LOG2_GAIN-1:0]  gain_act_q;

    // Stage 1: sample plus the config that was active when it was captured
    logic [N_INPUTS*INPUT_WIDTH-1:0]       s1_data_q;
    logic [N_OUTPUTS*N_INPUTS-1:0]         s1_sel_q;
    logic [N_OUTPUTS*WIDTH_LOG2_GAIN-1:0]  s1_gain_q;

    logic [1:0]                            fill_cnt_q;
    logic [N_OUTPUTS-1:0]                  sat_q;
    logic [N_OUTPUTS-1:0]                  sat_d;
    logic [N_OUTPUTS-1:0]                  lane_clip;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_act_q  <= '0;
            gain_act_q <= '0;
            s1_data_q  <= '0;
            s1_sel_q   <= '0;
            s1_gain_q  <= '0;
            fill_cnt_q <= '0;
            sat_q      <= '0;
        end else begin
            if (update_i) begin
                sel_act_q  <= add_select_i;
                gain_act_q <= log2_gain_i;
            end
            // Old active config goes with this sample; a new one applies
            // from the next capture on.
            s1_data_q <= data_i;
            s1_sel_q  <= sel_act_q;
            s1_gain_q <= gain_act_q;
            if (fill_cnt_q != 2'd3) begin
                fill_cnt_q <= fill_cnt_q + 2'd1;
            end
            sat_q <= sat_d;
        end
    end

    // A clip on the same edge as a clear keeps the flag set.
    always_comb begin
        sat_d = (sat_q & ~{N_OUTPUTS{sat_clear_i}}) | lane_clip;
    end

    generate
        for (genvar gi = 0; gi < N_OUTPUTS; gi++) begin : gen_out
            logic signed [SUM_WIDTH-1:0]   sum_d;
            logic signed [SUM_WIDTH-1:0]   sum_q;
            logic [WIDTH_LOG2_GAIN-1:0]    gain_q;

            always_comb begin
                sum_d = '0;
                for (int k = 0; k < N_INPUTS; k++) begin
                    if (s1_sel_q[gi*N_INPUTS + k]) begin
                        sum_d = sum_d + SUM_WIDTH'($signed(s1_data_q[k*INPUT_WIDTH +: INPUT_WIDTH]));
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sum_q  <= '0;
                    gain_q <= '0;
                end else begin
                    sum_q  <= sum_d;
                    gain_q <= s1_gain_q[gi*WIDTH_LOG2_GAIN +: WIDTH_LOG2_GAIN];
                end
            end

            shift_saturate_lane #(
                .SUM_WIDTH       (SUM_WIDTH),
                .OUTPUT_WIDTH    (OUTPUT_WIDTH),
                .MAX_LOG2_GAIN   (MAX_LOG2_GAIN),
                .WIDTH_LOG2_GAIN (WIDTH_LOG2_GAIN)
            ) u_lane (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .sum_i  (sum_q),
                .gain_i (gain_q),
                .data_o (data_o[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
                .clip_o (lane_clip[gi])
            );
        end
    endgenerate

    assign valid_o = (fill_cnt_q == 2'd3);
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_conditional_adder_gain_nxm.sv
// ---------------------------------------------------------------------------
// Bench for conditional_adder_gain_nxm. Two instances share all stimulus:
// inst 0 uses MAX_LOG2_GAIN=3, inst 1 uses MAX_LOG2_GAIN=2 (gain 3 acts as 2).
// The driver pushes the expected outputs of each captured sample into a
// queue; the monitor pops one entry whenever valid_o should be high.
// ---------------------------------------------------------------------------
module tb_conditional_adder_gain_nxm;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int IW = 14;
    localparam int OW = 14;
    localparam int WG = 2;
    localparam int MAXG [2] = '{3, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     upd;
    logic                     clr;
    int                       d [NI];
    logic [NO-1:0][NI-1:0]    sel;
    logic [NO-1:0][WG-1:0]    gain;
    logic [NI*IW-1:0]         data_bus;

    logic [1:0][NO*OW-1:0]    dout;
    logic [1:0]               vld;
    logic [1:0][NO-1:0]       sat;

    always_comb begin
        data_bus = '0;
        for (int k = 0; k < NI; k++) begin
            data_bus[k*IW +: IW] = d[k][IW-1:0];
        end
    end

    conditional_adder_gain_nxm #(
        .N_INPUTS(NI), .N_OUTPUTS(NO), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
        .MAX_LOG2_GAIN(3), .WIDTH_LOG2_GAIN(WG)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .data_i(data_bus), .add_select_i(sel),
        .log2_gain_i(gain), .update_i(upd), .sat_clear_i(clr),
        .data_o(dout[0]), .valid_o(vld[0]), .sat_o(sat[0])
    );

    conditional_adder_gain_nxm #(
        .N_INPUTS(NI), .N_OUTPUTS(NO), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
        .MAX_LOG2_GAIN(2), .WIDTH_LOG2_GAIN(WG)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .data_i(data_bus), .add_select_i(sel),
        .log2_gain_i(gain), .update_i(upd), .sat_clear_i(clr),
        .data_o(dout[1]), .valid_o(vld[1]), .sat_o(sat[1])
    );

    typedef struct packed {
        logic [1:0][NO-1:0][OW-1:0] val;
        logic [1:0][NO-1:0]         clip;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;

    logic [NO-1:0][NI-1:0] act_sel;
    logic [NO-1:0][WG-1:0] act_gain;

    // Reference: sum of selected inputs times 2^min(g,maxg), clipped.
    function automatic int ref_mix(input int dd [NI], input logic [NI-1:0] s,
                                   input int g, input int maxg, output bit clipped);
        int sum;
        int v;
        int lim;
        lim = 1 << (OW - 1);
        sum = 0;
        for (int k = 0; k < NI; k++) begin
            if (s[k]) sum += dd[k];
        end
        if (g > maxg) g = maxg;
        v = sum * (1 << g);
        clipped = 1'b0;
        if (v > lim - 1) begin
            v = lim - 1;
            clipped = 1'b1;
        end else if (v < -lim) begin
            v = -lim;
            clipped = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string name, input int inst, input int o,
                         input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s inst%0d out%0d: got %0d expected %0d", name, inst, o, got, expv);
        end
    endtask

    // One clock edge: record what the DUT captures at this edge.
    task automatic tick();
        exp_t e;
        bit   c;
        int   v;
        @(posedge clk);
        if (rst) begin
            sb.delete();
            act_sel  = '0;
            act_gain = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < NO; j++) begin
                    v = ref_mix(d, act_sel[j], int'(act_gain[j]), MAXG[i], c);
                    e.val[i][j]  = v[OW-1:0];
                    e.clip[i][j] = c;
                end
            end
            sb.push_back(e);
            if (upd) begin
                act_sel  = sel;
                act_gain = gain;
            end
        end
        #1;
    endtask

    // Monitor
    initial begin
        bit                 clr_s;
        bit                 rst_s;
        int                 rel;
        bit                 exp_valid;
        logic [1:0][NO-1:0] sticky;
        exp_t               e;
        int                 got;
        rel    = 0;
        sticky = '0;
        forever begin
            @(posedge clk);
            clr_s = clr;
            rst_s = rst;
            @(negedge clk);
            if (rst_s) begin
                rel    = 0;
                sticky = '0;
            end else if (rel < 3) begin
                rel++;
            end
            exp_valid = !rst_s && (rel >= 3);
            for (int i = 0; i < 2; i++) begin
                check("valid", i, 0, int'(vld[i]), int'(exp_valid));
            end
            if (exp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
                end else begin
                    e = sb.pop_front();
                    n_pops++;
                    for (int i = 0; i < 2; i++) begin
                        for (int j = 0; j < NO; j++) begin
                            got = int'($signed(dout[i][j*OW +: OW]));
                            check("data", i, j, got, int'($signed(e.val[i][j])));
                            sticky[i][j] = (sticky[i][j] & ~clr_s) | e.clip[i][j];
                            check("sat", i, j, int'(sat[i][j]), int'(sticky[i][j]));
                        end
                    end
                    $display("sample %0d: a=[%0d,%0d] b=[%0d,%0d] sat_a=%b sat_b=%b", n_pops,
                             $signed(dout[0][0 +: OW]), $signed(dout[0][OW +: OW]),
                             $signed(dout[1][0 +: OW]), $signed(dout[1][OW +: OW]),
                             sat[0], sat[1]);
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < NO; j++) begin
                        check("idle_data", i, j, int'($signed(dout[i][j*OW +: OW])), 0);
                        check("idle_sat", i, j, int'(sat[i][j]), 0);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        upd = 1'b0;
        clr = 1'b0;
        sel = '0;
        gain = '0;
        act_sel = '0;
        act_gain = '0;
        foreach (d[k]) d[k] = 0;
        repeat (2) tick();
        rst = 1'b0;

        // Single input passthrough
        sel[0] = 4'b0001; gain[0] = 2'd0; d[0] = 100;
        upd = 1'b1; tick(); upd = 1'b0;
        repeat (7) tick();

        // Two-input sum with gain 2, four-input sum with gain 0
        sel[0] = 4'b0011; gain[0] = 2'd2;
        sel[1] = 4'b1111; gain[1] = 2'd0;
        d[0] = 100; d[1] = 150; d[2] = 275; d[3] = 515;
        upd = 1'b1; tick(); upd = 1'b0;
        repeat (5) tick();

        // Positive clip, sticky, then clear with quiet inputs
        sel[0] = 4'b1111; gain[0] = 2'd0;
        foreach (d[k]) d[k] = 8191;
        upd = 1'b1; tick(); upd = 1'b0;
        repeat (5) tick();
        foreach (d[k]) d[k] = 0;
        repeat (3) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (3) tick();

        // Negative clip; clear while still clipping keeps the flag
        sel[0] = 4'b0011; gain[0] = 2'd1;
        d[0] = -5000; d[1] = -5000;
        upd = 1'b1; tick(); upd = 1'b0;
        repeat (4) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (3) tick();

        // Ramp with shadow ports churning, one update strobe
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < NI; k++) d[k] = c * 97 + k * 31 - 900;
            sel  = NO*NI'($urandom);
            gain = NO*WG'($urandom);
            upd  = (c == 10);
            tick();
        end
        upd = 1'b0;

        // Random traffic with occasional updates, clears and resets
        for (int c = 0; c < 150; c++) begin
            for (int k = 0; k < NI; k++) d[k] = int'($urandom_range(0, 16383)) - 8192;
            sel  = NO*NI'($urandom);
            gain = NO*WG'($urandom);
            upd  = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 49) == 0);
            tick();
        end
        upd = 1'b0; clr = 1'b0; rst = 1'b0;

        // Reset in the middle of a ramp
        sel = {4'b1010, 4'b0111}; gain = {2'd3, 2'd1};
        upd = 1'b1; tick(); upd = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < NI; k++) d[k] = c * 300 + k * 50;
            tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        sel = {4'b1111, 4'b0001}; gain = {2'd3, 2'd3};
        upd = 1'b1; tick(); upd = 1'b0;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < NI; k++) d[k] = c * 211 + k * 13;
            tick();
        end

        repeat (4) tick();
        @(negedge clk);
        n_checks++;
        if (n_pops < 100) begin
            n_fail++;
            $display("FAIL sample_count: got %0d samples expected at least 100", n_pops);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conditional_adder_gain_nxm.md
# conditional_adder_gain_nxm

Parametrised N-input, M-output mixing stage for the pt_feedback chain: each output sums a runtime-selected subset of the signed input channels, applies a per-output power-of-two gain and saturates to the output width. Generalises the fixed 4x2 adder plus single coarse-gain path into one pipelined block. Adds double-buffered configuration with atomic update, a valid flag during pipeline fill, and sticky per-output saturation flags.

## Interface
- N_INPUTS, 4: number of input channels (≥2)
- N_OUTPUTS, 2: number of output channels (≥1)
- INPUT_WIDTH, 14: signed input sample width
- OUTPUT_WIDTH, 14: signed output sample width
- MAX_LOG2_GAIN, 3: largest shift applied; larger requests clamp to this
- WIDTH_LOG2_GAIN, 2: width of each gain field

Ports:
- clk_i  in  1  single system clock; everything sampled on rising edge
- rst_i  in  1  synchronous, active-high reset
- data_i  in  N_INPUTS*INPUT_WIDTH  packed signed inputs; channel k at bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- add_select_i  in  N_OUTPUTS*N_INPUTS  shadow select; bit k of field j adds input k into output j
- log2_gain_i  in  N_OUTPUTS*WIDTH_LOG2_GAIN  shadow gain, one field per output
- update_i  in  1  strobe: copy shadow select/gain into active config
- sat_clear_i  in  1  clear all sticky saturation flags
- data_o  out  N_OUTPUTS*OUTPUT_WIDTH  packed signed outputs, same packing as data_i
- valid_o  out  1  high when data_o reflects real input samples
- sat_o  out  N_OUTPUTS  sticky saturation flag per output

## Operation
- SUM_WIDTH = INPUT_WIDTH + clog2(N_INPUTS); all arithmetic signed two's complement, sign-extended to SUM_WIDTH; the sum never overflows.
- Stage 1: register data_i together with the active config (select, gain) current that cycle; config travels with its sample.
- Stage 2: per output, masked sum of selected inputs. An empty select gives 0.
- Stage 3: per output, g = min(gain, MAX_LOG2_GAIN); value = sum << g, computed at SUM_WIDTH+MAX_LOG2_GAIN bits; clip to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1]; register into data_o.
- Active config: loaded from the shadow ports on a cycle with update_i=1. Never changes otherwise. Shadow ports may toggle freely without effect.
- Saturation: a clip in stage 3 for output j sets sat_o[j] in the same cycle data_o updates. sat_clear_i clears all flags. On simultaneous clip and clear, set wins for that output.
- valid_o: a 2-bit fill counter. 0 after reset, then rises on the 3rd cycle after rst_i deasserts and stays high.

## Timing
- Latency 3 cycles: data_i sampled at edge n appears on data_o after edge n+2 (visible cycle n+3).
- update_i high at edge n: samples captured at edge n+1 and later use the new config. The sample at edge n uses the old config. No output sample ever mixes configs.
- update_i held high: active config tracks the shadow ports every cycle.
- Reset (rst_i high at an edge, including mid-stream): next cycle data_o=0, valid_o=0, sat_o=0, active select=0, active gain=0, all pipeline registers 0. update_i and sat_clear_i are ignored during reset.
- Throughput: one sample per clock, no stalls, no backpressure.

## Structure
- Shared package pt_feedback_pkg holds the clog2 helper, the SUM_WIDTH derivation, and a signed saturate(value, width) function, for reuse by other pt_feedback blocks.
- One sub-module, shift_saturate_lane: clamp gain, shift, clip, register, produce the per-lane clip pulse. Instantiate N_OUTPUTS times with a generate loop.
- Config registers, adder tree, sticky flags and valid counter live in the top.

## Test plan
- Defaults; select out0=0001, gain 0; data0=100 constant → data_o[0]=100 from cycle 3 after first sample; valid_o rises 3 cycles after reset release; sat_o=00.
- Select out0=0011, gain 2; data0=100, data1=150 → out0=1000. Select out1=1111, gain 0; inputs 100/150/275/515 → out1=1040.
- All inputs 8191, out0 select 1111, gain 0 → out0=8191, sat_o[0]=1 and stays set. Then sat_clear_i pulse with inputs 0 → sat_o[0]=0.
- data0=data1=-5000, select 0011, gain 1 → out=-8192, sat_o set. Same cycle sat_clear_i and a new clip → flag remains 1.
- Ramp inputs, change shadow select every cycle, pulse update_i once → each output equals the model under exactly one config; switchover on the sample captured one edge after the strobe.
- Instance with MAX_LOG2_GAIN=2, WIDTH_LOG2_GAIN=2: gain 3 acts as 2. Assert rst_i mid-ramp → next cycle all outputs 0, valid_o low for 3 cycles after release.
